// File: rtl/poly_mult_pkg.sv
// Shared types and size helpers for the polynomial tile scheduler.
package poly_mult_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, COMMIT, FINISH} state_t;

  function automatic int tiles(input int width, input int tile_width);
    return width / tile_width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int off_width(input int width_a, input int width_b);
    return idx_width(width_a + width_b - 1);
  endfunction

  localparam int DEF_A_W  = 27;
  localparam int DEF_B_W  = 27;
  localparam int DEF_A_TW = 3;
  localparam int DEF_B_TW = 9;

  localparam int NA      = tiles(DEF_A_W, DEF_A_TW);
  localparam int NB      = tiles(DEF_B_W, DEF_B_TW);
  localparam int A_IDX_W = idx_width(NA);
  localparam int B_IDX_W = idx_width(NB);
  localparam int OFF_W   = off_width(DEF_A_W, DEF_B_W);

endpackage

// File: rtl/poly_tile_index_counter.sv
// Tile-pair index walker: A index innermost, B index outer, with registered
// output offset a_idx*A_TW + b_idx*B_TW.
module poly_tile_index_counter #(
  parameter int NA_P = 9,
  parameter int NB_P = 3,
  parameter int A_TW = 3,
  parameter int B_TW = 9,
  parameter int AIW  = 4,
  parameter int BIW  = 2,
  parameter int OW   = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  output logic [AIW-1:0] a_idx,
  output logic [BIW-1:0] b_idx,
  output logic [OW-1:0]  offset,
  output logic           last
);

  logic           a_wrap;
  logic           b_wrap;
  logic [AIW-1:0] a_nxt;
  logic [BIW-1:0] b_nxt;
  logic [OW-1:0]  off_nxt;

  assign a_wrap = (a_idx == AIW'(NA_P - 1));
  assign b_wrap = (b_idx == BIW'(NB_P - 1));
  assign last   = a_wrap && b_wrap;

  always_comb begin
    a_nxt = a_idx;
    b_nxt = b_idx;
    if (clear) begin
      a_nxt = '0;
      b_nxt = '0;
    end else if (advance) begin
      if (a_wrap) begin
        a_nxt = '0;
        b_nxt = b_wrap ? '0 : b_idx + 1'b1;
      end else begin
        a_nxt = a_idx + 1'b1;
      end
    end
    off_nxt = OW'(int'(a_nxt) * A_TW + int'(b_nxt) * B_TW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_idx  <= '0;
      b_idx  <= '0;
      offset <= '0;
    end else begin
      a_idx  <= a_nxt;
      b_idx  <= b_nxt;
      offset <= off_nxt;
    end
  end

endmodule

// File: rtl/polynomial_tile_scheduler.sv
// Issues A/B tile pairs to the multiplier, waits for the adder tree, and hands
// each result to the output loader. Optional stall counter: TILE_SCHED_PERF_CNT_EN.
module polynomial_tile_scheduler
  import poly_mult_pkg::*;
#(
  parameter int POLY_A_WIDTH      = 27,
  parameter int POLY_B_WIDTH      = 27,
  parameter int POLY_A_TILE_WIDTH = 3,
  parameter int POLY_B_TILE_WIDTH = 9,
  localparam int A_TILES = tiles(POLY_A_WIDTH, POLY_A_TILE_WIDTH),
  localparam int B_TILES = tiles(POLY_B_WIDTH, POLY_B_TILE_WIDTH),
  localparam int AIW     = idx_width(A_TILES),
  localparam int BIW     = idx_width(B_TILES),
  localparam int OW      = off_width(POLY_A_WIDTH, POLY_B_WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           tile_valid,
  input  logic           tile_accept,
  output logic [AIW-1:0] a_tile_idx,
  output logic [BIW-1:0] b_tile_idx,
  output logic [OW-1:0]  out_offset,
  input  logic           adder_tree_valid,
  output logic           tile_ready,
  input  logic           loader_ready,
  output logic           busy,
`ifdef TILE_SCHED_PERF_CNT_EN
  output logic           done,
  output logic [31:0]    stall_cycles
`else
  output logic           done
`endif
);

  state_t state;
  logic   last;
  logic   clear;
  logic   advance;

  assign clear   = (state == IDLE) && start;
  assign advance = (state == COMMIT) && loader_ready;

  poly_tile_index_counter #(
    .NA_P (A_TILES),
    .NB_P (B_TILES),
    .A_TW (POLY_A_TILE_WIDTH),
    .B_TW (POLY_B_TILE_WIDTH),
    .AIW  (AIW),
    .BIW  (BIW),
    .OW   (OW)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .a_idx   (a_tile_idx),
    .b_idx   (b_tile_idx),
    .offset  (out_offset),
    .last    (last)
  );

  // Outputs are set on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tile_valid <= 1'b0;
      tile_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tile_ready <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= ISSUE;
          tile_valid <= 1'b1;
          busy       <= 1'b1;
        end
        ISSUE: if (tile_valid && tile_accept) begin
          state      <= WAIT_RES;
          tile_valid <= 1'b0;
        end
        WAIT_RES: if (adder_tree_valid) state <= COMMIT;
        COMMIT: if (loader_ready) begin
          tile_ready <= 1'b1;
          if (last) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state      <= ISSUE;
            tile_valid <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_SCHED_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (clear) begin
      stall_cycles <= '0;
    end else if (((state == COMMIT) && !loader_ready) ||
                 ((state == ISSUE) && !tile_accept)) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_polynomial_tile_scheduler.sv
// Directed bench for polynomial_tile_scheduler (default parameters).
module tb_polynomial_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, tile_accept, adder_tree_valid, loader_ready;
  logic       tile_valid, tile_ready, busy, done;
  logic [3:0] a_tile_idx;
  logic [1:0] b_tile_idx;
  logic [5:0] out_offset;
`ifdef TILE_SCHED_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  polynomial_tile_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .tile_valid       (tile_valid),
    .tile_accept      (tile_accept),
    .a_tile_idx       (a_tile_idx),
    .b_tile_idx       (b_tile_idx),
    .out_offset       (out_offset),
    .adder_tree_valid (adder_tree_valid),
    .tile_ready       (tile_ready),
    .loader_ready     (loader_ready),
    .busy             (busy),
`ifdef TILE_SCHED_PERF_CNT_EN
    .done             (done),
    .stall_cycles     (stall_cycles)
`else
    .done             (done)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_issue = 0, n_ready = 0, n_done = 0, n_dbl = 0;
  logic prev_ready = 1'b0;
  int   pa[256], pb[256], po[256];

  always @(negedge clk) begin
    if (tile_valid && tile_accept && n_issue < 256) begin
      pa[n_issue] = int'(a_tile_idx);
      pb[n_issue] = int'(b_tile_idx);
      po[n_issue] = int'(out_offset);
      n_issue++;
    end
    if (tile_ready) n_ready++;
    if (tile_ready && prev_ready) n_dbl++;
    prev_ready = tile_ready;
    if (done) n_done++;
  end

  typedef struct {
    int pair;
    int a;
    int b;
    int off;
  } vec_t;
  vec_t vt[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base_d, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      tick();
      if (n_done > base_d) break;
    end
    checks++;
    if (n_done <= base_d) begin
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", maxc);
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "timeout");
  end

  int bi, br, bd;

  initial begin
    vt[0] = '{1, 0, 0, 0};
    vt[1] = '{2, 1, 0, 3};
    vt[2] = '{4, 3, 0, 9};
    vt[3] = '{9, 8, 0, 24};
    vt[4] = '{10, 0, 1, 9};
    vt[5] = '{13, 3, 1, 18};
    vt[6] = '{19, 0, 2, 18};
    vt[7] = '{27, 8, 2, 42};

    rst = 1'b0; start = 1'b0; tile_accept = 1'b0;
    adder_tree_valid = 1'b0; loader_ready = 1'b0;
    tick(); tick();
    chk("rst_tile_valid", tile_valid, 0);
    chk("rst_tile_ready", tile_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_idx", a_tile_idx, 0);
    chk("rst_b_idx", b_tile_idx, 0);
    chk("rst_offset", out_offset, 0);
    rst = 1'b1;
    tick(); tick();
    chk("idle_busy", busy, 0);

    // Full job with every handshake tied high
    tile_accept = 1'b1; adder_tree_valid = 1'b1; loader_ready = 1'b1;
    bi = n_issue; br = n_ready; bd = n_done;
    start_job();
    chk("run_busy", busy, 1);
    wait_done(bd, 200);
    chk("run_pairs", n_issue - bi, 27);
    chk("run_ready_pulses", n_ready - br, 27);
    chk("run_done_pulses", n_done - bd, 1);
    chk("run_busy_after", busy, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pair%0d_a", vt[k].pair), pa[bi + vt[k].pair - 1], vt[k].a);
      chk($sformatf("pair%0d_b", vt[k].pair), pb[bi + vt[k].pair - 1], vt[k].b);
      chk($sformatf("pair%0d_off", vt[k].pair), po[bi + vt[k].pair - 1], vt[k].off);
    end
`ifdef TILE_SCHED_PERF_CNT_EN
    chk("run_stall", int'(stall_cycles), 0);
`endif

    // Issue stall with spurious start/adder_tree_valid, then a mid-job start
    tile_accept = 1'b0;
    bi = n_issue; br = n_ready; bd = n_done;
    start_job();
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_tile_valid", tile_valid, 1);
      chk("hold_a_idx", a_tile_idx, 0);
      chk("hold_tile_ready", tile_ready, 0);
      tick();
    end
    start = 1'b0;
    tile_accept = 1'b1;
    repeat (10) tick();
    start_job();
    wait_done(bd, 200);
    chk("hold_pairs", n_issue - bi, 27);
    chk("hold_ready_pulses", n_ready - br, 27);
    chk("hold_done_pulses", n_done - bd, 1);
    chk("hold_first_a", pa[bi], 0);
    chk("hold_last_off", po[bi + 26], 42);
`ifdef TILE_SCHED_PERF_CNT_EN
    chk("hold_stall", int'(stall_cycles), 5);
`endif

    // Loader back-pressure in COMMIT
    loader_ready = 1'b0;
    bi = n_issue; br = n_ready; bd = n_done;
    start_job();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("bp_tile_ready_low", tile_ready, 0);
      tick();
    end
    loader_ready = 1'b1;
    tick();
    chk("bp_tile_ready_pulse", tile_ready, 1);
    chk("bp_a_advanced", a_tile_idx, 1);
`ifdef TILE_SCHED_PERF_CNT_EN
    chk("bp_stall", int'(stall_cycles), 4);
`endif
    tick();
    chk("bp_tile_ready_drop", tile_ready, 0);
    wait_done(bd, 200);
    chk("bp_ready_pulses", n_ready - br, 27);

    // Reset in the middle of a job
    bi = n_issue; bd = n_done;
    start_job();
    for (int k = 0; k < 100 && (n_issue - bi) < 13; k++) tick();
    chk("mid_reached_pair13", n_issue - bi, 13);
    rst = 1'b0;
    #1;
    chk("mrst_tile_valid", tile_valid, 0);
    chk("mrst_tile_ready", tile_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_a_idx", a_tile_idx, 0);
    chk("mrst_b_idx", b_tile_idx, 0);
    chk("mrst_offset", out_offset, 0);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("mrst_no_done", n_done - bd, 0);
    chk("mrst_stay_idle", busy, 0);
    chk("mrst_no_issue", tile_valid, 0);
    bi = n_issue; br = n_ready; bd = n_done;
    start_job();
    wait_done(bd, 200);
    chk("restart_first_a", pa[bi], 0);
    chk("restart_first_b", pb[bi], 0);
    chk("restart_first_off", po[bi], 0);
    chk("restart_ready_pulses", n_ready - br, 27);
    chk("ready_single_cycle", n_dbl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
